// File: rtl/reg_bank_param_if.sv
// Datapath-side bundle for the parametrised register bank. The master side drives
// bus codes, data sources and control strobes; the slave side (the bank) drives the bus and register views.
interface reg_bank_param_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_GPR = 4,
  parameter int ADDR_W  = 11,
  parameter int SEL_W   = 4
);
  logic [SEL_W-1:0]          select;
  logic [SEL_W-1:0]          load;
  logic                      bus_en;
  logic                      load_en;
  logic [DATA_W-1:0]         mem_data;
  logic [DATA_W-1:0]         alu_data;
  logic [DATA_W-1:0]         alu_hi;
  logic                      hi_load;
  logic                      inc_pc;
  logic                      stat_en;
  logic                      z;
  logic                      n;
  logic                      c;
  logic                      ov;
  logic                      ctx_save;
  logic                      ctx_restore;

  logic [DATA_W-1:0]         bus;
  logic [ADDR_W-1:0]         address_for_mem;
  logic [DATA_W-1:0]         instruction;
  logic [NUM_GPR*DATA_W-1:0] gpr_flat;
  logic [DATA_W-1:0]         program_counter;
  logic [DATA_W-1:0]         base_address;
  logic [DATA_W-1:0]         data_register;
  logic [7:0]                immediate;
  logic [11:0]               immediate12bit;
  logic                      status_z;
  logic                      status_n;
  logic                      status_c;
  logic                      status_ov;

  modport master (
    output select, load, bus_en, load_en, mem_data, alu_data, alu_hi, hi_load,
           inc_pc, stat_en, z, n, c, ov, ctx_save, ctx_restore,
    input  bus, address_for_mem, instruction, gpr_flat, program_counter,
           base_address, data_register, immediate, immediate12bit,
           status_z, status_n, status_c, status_ov
  );

  modport slave (
    input  select, load, bus_en, load_en, mem_data, alu_data, alu_hi, hi_load,
           inc_pc, stat_en, z, n, c, ov, ctx_save, ctx_restore,
    output bus, address_for_mem, instruction, gpr_flat, program_counter,
           base_address, data_register, immediate, immediate12bit,
           status_z, status_n, status_c, status_ov
  );
endinterface

// File: rtl/reg_bank_param.sv
// CAP17 register bank: NUM_GPR data registers plus AR/DR/SR/BA/PC/HI/LO/IR on one shared bus,
// with a one-deep PC/SR shadow for interrupt entry and return.
module reg_bank_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_GPR  = 4,
  parameter int ADDR_W   = 11,
  parameter int SEL_W    = 4,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0,
  parameter int RESET_BA = 1
) (
  input logic              clk,
  input logic              rst,
  reg_bank_param_if.slave  bif
);

  localparam int G = NUM_GPR;
  localparam logic [SEL_W-1:0] C_AR  = SEL_W'(G + 1);
  localparam logic [SEL_W-1:0] C_DR  = SEL_W'(G + 2);
  localparam logic [SEL_W-1:0] C_SR  = SEL_W'(G + 3);
  localparam logic [SEL_W-1:0] C_BA  = SEL_W'(G + 4);
  localparam logic [SEL_W-1:0] C_PC  = SEL_W'(G + 5);
  localparam logic [SEL_W-1:0] C_HI  = SEL_W'(G + 6);
  localparam logic [SEL_W-1:0] C_LO  = SEL_W'(G + 7);
  localparam logic [SEL_W-1:0] C_IR  = SEL_W'(G + 8);
  localparam logic [SEL_W-1:0] C_ALU = SEL_W'(G + 9);
  localparam logic [SEL_W-1:0] C_MEM = SEL_W'(G + 10);

  logic [DATA_W-1:0] gpr [NUM_GPR];
  logic [ADDR_W-1:0] ar;
  logic [DATA_W-1:0] dr, sr, ba, pc, hi, lo, ir;
  logic [DATA_W-1:0] sh_pc, sh_sr;
  logic [DATA_W-1:0] bus_mux;
  logic [NUM_GPR*DATA_W-1:0] flat;
  logic wr;

  assign wr = bif.bus_en & bif.load_en;

  always_comb begin
    bus_mux = '0;
    if (bif.bus_en) begin
      for (int i = 0; i < NUM_GPR; i++)
        if (bif.select == SEL_W'(i + 1)) bus_mux = gpr[i];
      case (bif.select)
        C_AR:    bus_mux = DATA_W'(ar);
        C_DR:    bus_mux = dr;
        C_SR:    bus_mux = sr;
        C_BA:    bus_mux = ba;
        C_PC:    bus_mux = pc;
        C_HI:    bus_mux = hi;
        C_LO:    bus_mux = lo;
        C_IR:    bus_mux = ir;
        C_ALU:   bus_mux = bif.alu_data;
        C_MEM:   bus_mux = bif.mem_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++)
        if (wr && bif.load == SEL_W'(i + 1)) gpr[i] <= bus_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar <= '0;
      dr <= '0;
      ba <= DATA_W'(RESET_BA);
      lo <= '0;
      ir <= '0;
    end else if (wr) begin
      if (bif.load == C_AR) ar <= bus_mux[ADDR_W-1:0];
      if (bif.load == C_DR) dr <= bus_mux;
      if (bif.load == C_BA) ba <= bus_mux;
      if (bif.load == C_LO) lo <= bus_mux;
      if (bif.load == C_IR) ir <= bus_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         hi <= '0;
    else if (wr && bif.load == C_HI) hi <= bus_mux;
    else if (bif.hi_load)            hi <= bif.alu_hi;
  end

  // Restore outranks a bus load so an interrupt return cannot be clobbered by the same microstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         pc <= DATA_W'(RESET_PC);
    else if (bif.ctx_restore)        pc <= sh_pc;
    else if (wr && bif.load == C_PC) pc <= bus_mux;
    else if (bif.inc_pc)             pc <= pc + DATA_W'(PC_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sr <= '0;
    else if (bif.ctx_restore)        sr <= sh_sr;
    else if (wr && bif.load == C_SR) sr <= bus_mux;
    else if (bif.stat_en)            sr <= {bif.z, bif.n, bif.c, bif.ov, sr[DATA_W-5:0]};
  end

  // Shadows sample pre-edge PC/SR, so save+restore in one cycle is a swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_pc <= '0;
      sh_sr <= '0;
    end else if (bif.ctx_save) begin
      sh_pc <= pc;
      sh_sr <= sr;
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_GPR; i++) flat[i*DATA_W +: DATA_W] = gpr[i];
  end

  assign bif.bus             = bus_mux;
  assign bif.address_for_mem = ar;
  assign bif.instruction     = ir;
  assign bif.gpr_flat        = flat;
  assign bif.program_counter = pc;
  assign bif.base_address    = ba;
  assign bif.data_register   = dr;
  assign bif.immediate       = ir[7:0];
  assign bif.immediate12bit  = ir[11:0];
  assign bif.status_z        = sr[DATA_W-1];
  assign bif.status_n        = sr[DATA_W-2];
  assign bif.status_c        = sr[DATA_W-3];
  assign bif.status_ov       = sr[DATA_W-4];

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
Parametrised next-generation CPU register bank for the single-bus CAP17 datapath. It holds NUM_GPR general data registers plus the special registers: AR (memory address), DR, SR, BA, PC, HI, LO and IR. It drives the shared bus from a selected source and loads a selected destination on the clock edge. It adds, over the previous bank: true clocked writes, reset, defined priorities, PC wrap, out-of-range handling, and a one-cycle PC/SR context save/restore for interrupt entry and return.

Parameters:
DATA_W, 16, register and bus width; must be >= 12.
NUM_GPR, 4, number of general data registers D0..D(NUM_GPR-1); range 1..16.
ADDR_W, 11, AR width; must be <= DATA_W.
SEL_W, 4, select/load code width; must be >= clog2(NUM_GPR+11).
PC_STEP, 1, PC increment amount.
RESET_PC, 0, PC value after reset.
RESET_BA, 1, BA value after reset.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
select  in  SEL_W  bus source code.
load  in  SEL_W  bus destination code.
bus_en  in  1  enables bus drive and load.
load_en  in  1  qualifies load.
mem_data  in  DATA_W  memory read data (source only).
alu_data  in  DATA_W  ALU result (source only).
alu_hi  in  DATA_W  ALU upper product.
hi_load  in  1  HI <= alu_hi.
inc_pc  in  1  PC <= PC + PC_STEP.
stat_en  in  1  latch flags z, n, c, ov into SR.
z, n, c, ov  in  1 each  ALU flags.
ctx_save  in  1  shadow PC/SR <= PC/SR.
ctx_restore  in  1  PC/SR <= shadow PC/SR.
bus  out  DATA_W  shared datapath bus.
address_for_mem  out  ADDR_W  AR.
instruction  out  DATA_W  IR.
gpr_flat  out  NUM_GPR*DATA_W  D0 in the LSBs.
program_counter, base_address, data_register  out  DATA_W  PC, BA, DR.
immediate  out  8  IR[7:0].
immediate12bit  out  12  IR[11:0].
status_z, status_n, status_c, status_ov  out  1  SR[DATA_W-1..DATA_W-4].

Behaviour:
- Code map (G = NUM_GPR):
  - 0 ZERO
  - 1..G D0..D(G-1)
  - G+1 AR, G+2 DR, G+3 SR, G+4 BA, G+5 PC, G+6 HI, G+7 LO, G+8 IR
  - G+9 ALU (source only), G+10 MEM (source only)
  - Default G=4 gives codes 0..14.
- Bus, combinational:
  - bus_en=0 -> bus = 0.
  - Otherwise bus = the selected source.
  - AR is zero-extended onto the bus.
  - Unused select codes drive 0.
- Load, on the rising edge when bus_en & load_en:
  - The destination captures bus; AR takes bus[ADDR_W-1:0].
  - Codes 0, G+9, G+10 and unused codes write nothing.
  - Load to a register and bus source from the same register in the same cycle is legal; the register keeps the old value (bus reflects pre-edge contents).
- PC priority, per edge: rst > ctx_restore > bus load to PC > inc_pc > hold.
  - inc_pc wraps modulo 2^DATA_W.
- SR priority: rst > ctx_restore > bus load to SR (full word) > stat_en (top 4 bits only; lower bits unchanged) > hold.
- HI priority: bus load to HI > hi_load > hold.
- Context:
  - ctx_save captures the pre-edge PC and SR into shadow registers.
  - ctx_save and ctx_restore together swap: shadow gets the old PC/SR, PC/SR get the old shadow.
  - Shadows are not bus-visible.
- Latency:
  - A load is visible on outputs and bus one cycle after the edge.
  - Flags appear on status_* the cycle after stat_en.
- Reset, asynchronous, effective immediately including mid-operation:
  - PC = RESET_PC, BA = RESET_BA.
  - GPRs, AR, DR, SR, HI, LO, IR and shadows = 0.
  - bus = 0 only if bus_en=0 (bus stays combinational).
  - All derived outputs track their registers.

Test Plan:
- Reset with default params -> program_counter=0, base_address=1, gpr_flat=0, status_*=0; then inc_pc 3 cycles -> PC=3.
- select=14 (MEM) with mem_data=16'hA5C3, load=12 (IR) -> instruction=A5C3, immediate=C3, immediate12bit=5C3; then select=12 (IR), load=1 -> D0=A5C3.
- Load PC=FFFF, then inc_pc -> PC=0000; same cycle inc_pc=1 with load=9 (PC) and bus=0x0040 -> PC=0x0040 (load wins).
- stat_en with z=1, c=1, SR previously 0x0ABC -> SR=0xAABC; same cycle bus load of SR=0x1234 -> SR=0x1234.
- PC=0x0100, SR=0x8000: ctx_save; change PC to 0x0200, SR to 0; ctx_restore -> PC=0x0100, SR=0x8000; simultaneous save+restore -> swap verified.
- NUM_GPR=8, SEL_W=5: write D7 via load=8, read AR via select=9 with AR=0x7FF -> bus=0x07FF; unused load codes 19..31 modify nothing; rst asserted mid-load -> all registers at reset values immediately.
